// File: rtl/frame_dispatch_ctrl.sv
// Frame dispatcher: pops one descriptor from the frame FIFO, validates the one-hot channel,
// masks and Gray-codes the payload, then issues a one-cycle load to the idle target serializer.
module frame_dispatch_ctrl #(
    parameter int DATA_W  = 128,
    parameter int NUM_CH  = 8,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic                       clk_out,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       fifo_empty,
    output logic                       fifo_rd_en,
    input  logic [NUM_CH+3+DATA_W-1:0] fifo_rd_data,
    input  logic [NUM_CH-1:0]          ser_ready,
    output logic [NUM_CH-1:0]          ser_load,
    output logic [DATA_W-1:0]          ser_data,
    output logic [7:0]                 ser_len,
    output logic                       busy,
    output logic                       drop_pulse,
    output logic [CNT_W-1:0]           frame_cnt,
    output logic [CNT_W-1:0]           drop_cnt
);
    localparam int LANES = DATA_W / 16;
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CHK  = 3'd2,
        ST_WAIT = 3'd3,
        ST_LOAD = 3'd4
    } state_t;

    function automatic logic is_onehot(input logic [NUM_CH-1:0] v);
        return (v != {NUM_CH{1'b0}}) &&
               ((v & (v - {{(NUM_CH-1){1'b0}}, 1'b1})) == {NUM_CH{1'b0}});
    endfunction

    function automatic logic [DATA_W-1:0] gray_enc(input logic [DATA_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    state_t              state_r, next_s;
    logic [TMO_W-1:0]    tmo_r, tmo_next_s;
    logic [NUM_CH-1:0]   chan_r;
    logic                rd_s, drop_s, cap_s;
    logic [NUM_CH-1:0]   load_s;
    logic [NUM_CH-1:0]   sel_s;
    logic [2:0]          len_code_s;
    logic [DATA_W-1:0]   payload_s, masked_s;
    logic [7:0]          len_bits_s;

    logic                fifo_rd_en_r, busy_r, drop_pulse_r;
    logic [NUM_CH-1:0]   ser_load_r;
    logic [DATA_W-1:0]   ser_data_r;
    logic [7:0]          ser_len_r;
    logic [CNT_W-1:0]    frame_cnt_r, drop_cnt_r;

    assign sel_s      = fifo_rd_data[NUM_CH+3+DATA_W-1 -: NUM_CH];
    assign len_code_s = fifo_rd_data[DATA_W+2 -: 3];
    assign payload_s  = fifo_rd_data[DATA_W-1:0];
    assign len_bits_s = {1'b0, len_code_s, 4'd0} + 8'd16;

    // Keep only the 16-bit lanes that lie below the frame length
    always_comb begin
        masked_s = {DATA_W{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            if (i <= int'(len_code_s)) begin
                masked_s[i*16 +: 16] = payload_s[i*16 +: 16];
            end else begin
                masked_s[i*16 +: 16] = 16'd0;
            end
        end
    end

    // Next-state and strobe decode
    always_comb begin
        next_s     = state_r;
        tmo_next_s = tmo_r;
        rd_s       = 1'b0;
        drop_s     = 1'b0;
        cap_s      = 1'b0;
        load_s     = {NUM_CH{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (en && !fifo_empty) begin
                    next_s = ST_RD;
                    rd_s   = 1'b1;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_RD: next_s = ST_CHK;
            ST_CHK: begin
                if (is_onehot(sel_s)) begin
                    next_s     = ST_WAIT;
                    cap_s      = 1'b1;
                    tmo_next_s = {TMO_W{1'b0}};
                end else begin
                    next_s = ST_IDLE;
                    drop_s = 1'b1;
                end
            end
            ST_WAIT: begin
                if ((ser_ready & chan_r) != {NUM_CH{1'b0}}) begin
                    next_s = ST_LOAD;
                    load_s = chan_r;
                end else if (tmo_r == TMO_LAST) begin
                    next_s = ST_IDLE;
                    drop_s = 1'b1;
                end else begin
                    tmo_next_s = tmo_r + {{(TMO_W-1){1'b0}}, 1'b1};
                end
            end
            ST_LOAD: next_s = ST_IDLE;
            default: next_s = ST_IDLE;
        endcase
    end

    // Control state, wait timer and latched target channel
    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            tmo_r   <= {TMO_W{1'b0}};
            chan_r  <= {NUM_CH{1'b0}};
        end else begin
            state_r <= next_s;
            tmo_r   <= tmo_next_s;
            if (cap_s) begin
                chan_r <= sel_s;
            end
        end
    end

    // Registered outputs; strobes are produced one edge ahead so they align with their state
    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            fifo_rd_en_r <= 1'b0;
            busy_r       <= 1'b0;
            drop_pulse_r <= 1'b0;
            ser_load_r   <= {NUM_CH{1'b0}};
            ser_data_r   <= {DATA_W{1'b0}};
            ser_len_r    <= 8'd0;
            frame_cnt_r  <= {CNT_W{1'b0}};
            drop_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            fifo_rd_en_r <= rd_s;
            busy_r       <= (next_s != ST_IDLE);
            drop_pulse_r <= drop_s;
            ser_load_r   <= load_s;
            if (cap_s) begin
                ser_data_r <= gray_enc(masked_s);
                ser_len_r  <= len_bits_s;
            end
            if (load_s != {NUM_CH{1'b0}}) begin
                frame_cnt_r <= sat_inc(frame_cnt_r);
            end
            if (drop_s) begin
                drop_cnt_r <= sat_inc(drop_cnt_r);
            end
        end
    end

    assign fifo_rd_en = fifo_rd_en_r;
    assign busy       = busy_r;
    assign drop_pulse = drop_pulse_r;
    assign ser_load   = ser_load_r;
    assign ser_data   = ser_data_r;
    assign ser_len    = ser_len_r;
    assign frame_cnt  = frame_cnt_r;
    assign drop_cnt   = drop_cnt_r;

endmodule

// File: tb/tb_frame_dispatch_ctrl.sv
// Bench for frame_dispatch_ctrl: directed vector table, timing sequences and a randomized
// run scored against a frame-level reference model with FIFO and serializer models.
module tb_frame_dispatch_ctrl;
    localparam int DATA_W  = 128;
    localparam int NUM_CH  = 8;
    localparam int TIMEOUT = 32;
    localparam int CNT_W   = 16;
    localparam int FW      = NUM_CH + 3 + DATA_W;

    logic              clk_out = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              fifo_empty = 1'b1;
    logic              fifo_rd_en;
    logic [FW-1:0]     fifo_rd_data = '0;
    logic [NUM_CH-1:0] ser_ready = '1;
    logic [NUM_CH-1:0] ser_load;
    logic [DATA_W-1:0] ser_data;
    logic [7:0]        ser_len;
    logic              busy, drop_pulse;
    logic [CNT_W-1:0]  frame_cnt, drop_cnt;

    always #5 clk_out = ~clk_out;

    frame_dispatch_ctrl #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_out(clk_out), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .ser_ready(ser_ready),
        .ser_load(ser_load), .ser_data(ser_data), .ser_len(ser_len), .busy(busy),
        .drop_pulse(drop_pulse), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
    );

    typedef struct {
        bit           is_load;
        logic [7:0]   chan;
        logic [127:0] data;
        logic [7:0]   len;
    } exp_t;

    typedef struct {
        logic [7:0]   sel;
        logic [2:0]   lc;
        logic [127:0] pl;
        bit           exp_load;
        logic [127:0] exp_data;
        logic [7:0]   exp_len;
    } vec_t;

    exp_t          eq[$];
    logic [FW-1:0] fq[$];
    int            n_chk = 0, n_fail = 0;
    int            cyc_n = 0, rd_cnt = 0, m_loads = 0, m_drops = 0;
    int            last_rd_cyc = -100, last_load_cyc = -100, last_drop_cyc = -100;
    bit            ev_load = 1'b0, ev_drop = 1'b0;
    logic [7:0]    ld_val = '0;
    logic [127:0]  ld_data = '0;
    logic [7:0]    ld_len = '0;
    logic [NUM_CH-1:0] rdy = '1, block_mask = '0;
    int            hold[NUM_CH];
    int            hold_max = 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: actual=missing/unexpected required=none", name);
    endtask

    // Frame-level expectation: one-hot select and no stall means a load of gray(masked payload)
    function automatic exp_t model(input logic [7:0] sel, input logic [2:0] lc,
                                   input logic [127:0] pl, input bit stall);
        exp_t         e;
        int           len;
        logic [127:0] m;
        len = (int'(lc) + 1) * 16;
        m = '0;
        for (int i = 0; i < len; i++) m[i] = pl[i];
        e.is_load = ($countones(sel) == 1) && !stall;
        e.chan    = sel;
        e.len     = 8'(len);
        e.data    = m ^ (m >> 1);
        return e;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic push(input logic [7:0] sel, input logic [2:0] lc, input logic [127:0] pl,
                        input bit stall);
        exp_t e;
        fq.push_back({sel, lc, pl});
        fifo_empty = 1'b0;
        e = model(sel, lc, pl, stall);
        eq.push_back(e);
        if (e.is_load) m_loads++;
        else m_drops++;
    endtask

    // One clock: sample at negedge, score events, then update FIFO and serializer models
    task automatic cyc();
        exp_t e;
        @(negedge clk_out);
        cyc_n++;
        ev_load = (ser_load != '0);
        ev_drop = drop_pulse;
        if (fifo_rd_en) begin
            last_rd_cyc = cyc_n;
            rd_cnt++;
        end
        if (ev_load) begin
            last_load_cyc = cyc_n;
            ld_val = ser_load;
            ld_data = ser_data;
            ld_len = ser_len;
            chki("load_onehot", $countones(ser_load), 1);
            if (eq.size() == 0) flag("sb_unexpected_load");
            else begin
                e = eq.pop_front();
                chk("sb_kind_load", 1'b1, e.is_load);
                chk("sb_chan", ser_load, e.chan);
                chk("sb_data", ser_data, e.data);
                chk("sb_len", ser_len, e.len);
            end
        end
        if (ev_drop) begin
            last_drop_cyc = cyc_n;
            if (eq.size() == 0) flag("sb_unexpected_drop");
            else begin
                e = eq.pop_front();
                chk("sb_kind_drop", 1'b0, e.is_load);
            end
        end
        if (fifo_rd_en) begin
            if (fq.size() == 0) flag("fifo_underflow");
            else fifo_rd_data = fq.pop_front();
        end
        fifo_empty = (fq.size() == 0);
        for (int c = 0; c < NUM_CH; c++) begin
            if (ser_load[c]) begin
                if (!ser_ready[c]) flag("load_while_not_ready");
                rdy[c] = 1'b0;
                hold[c] = $urandom_range(1, hold_max);
            end else if (!rdy[c]) begin
                hold[c]--;
                if (hold[c] <= 0) rdy[c] = 1'b1;
            end
        end
        ser_ready = rdy & ~block_mask;
    endtask

    task automatic wait_ev(input int budget, output bit gl, output bit gd);
        gl = 1'b0;
        gd = 1'b0;
        for (int k = 0; k < budget; k++) begin
            cyc();
            if (ev_load || ev_drop) begin
                gl = ev_load;
                gd = ev_drop;
                break;
            end
        end
        if (!gl && !gd) flag("event_timeout");
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rd_en"}, fifo_rd_en, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_drop_pulse"}, drop_pulse, 1'b0);
        chk({tag, "_ser_load"}, ser_load, 8'h00);
        chk({tag, "_ser_data"}, ser_data, 128'd0);
        chk({tag, "_ser_len"}, ser_len, 8'd0);
        chk({tag, "_frame_cnt"}, frame_cnt, 16'd0);
        chk({tag, "_drop_cnt"}, drop_cnt, 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=no finish required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tv[8];
        int   p, rd0, rel, la, d0, guard;
        bit   gl, gd;

        tv[0] = '{8'h01, 3'd0, 128'hA55A, 1'b1, 128'hF7F7, 8'd16};
        tv[1] = '{8'h04, 3'd0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_1234, 1'b1, 128'h1B2E, 8'd16};
        tv[2] = '{8'h03, 3'd0, 128'h5555, 1'b0, 128'd0, 8'd0};
        tv[3] = '{8'h00, 3'd7, 128'hFFFF, 1'b0, 128'd0, 8'd0};
        tv[4] = '{8'h80, 3'd1, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0001_8000, 1'b1, 128'h14000, 8'd32};
        tv[5] = '{8'h10, 3'd7, 128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b1,
                  128'hC000_0000_0000_0000_0000_0000_0000_0000, 8'd128};
        tv[6] = '{8'h20, 3'd3, {128{1'b1}}, 1'b1, 128'h0000_0000_0000_0000_8000_0000_0000_0000, 8'd64};
        tv[7] = '{8'hFF, 3'd2, 128'h1, 1'b0, 128'd0, 8'd0};
        for (int c = 0; c < NUM_CH; c++) hold[c] = 0;

        repeat (3) cyc();
        chk_zero("reset");
        rst_n = 1'b1;
        en = 1'b1;
        repeat (2) cyc();

        for (int i = 0; i < 8; i++) begin
            p = cyc_n;
            push(tv[i].sel, tv[i].lc, tv[i].pl, 1'b0);
            wait_ev(20, gl, gd);
            chk("tv_is_load", gl, tv[i].exp_load);
            chki("tv_rd_latency", last_rd_cyc - p, 1);
            if (tv[i].exp_load) begin
                chki("tv_load_latency", last_load_cyc - p, 4);
                chk("tv_load_chan", ld_val, tv[i].sel);
                chk("tv_data", ld_data, tv[i].exp_data);
                chk("tv_len", ld_len, tv[i].exp_len);
            end else begin
                chki("tv_drop_latency", last_drop_cyc - p, 3);
            end
            if (i == 0) chk("t1_frame_cnt", frame_cnt, 16'd1);
            repeat (2) cyc();
        end
        chk("tv_fifo_drained", fifo_empty, 1'b1);
        chki("tv_frame_cnt", int'(frame_cnt), m_loads);
        chki("tv_drop_cnt", int'(drop_cnt), m_drops);

        // Head-of-line blocking on a busy channel
        block_mask = 8'h02;
        p = cyc_n;
        rd0 = rd_cnt;
        push(8'h02, 3'd7, rand128(), 1'b0);
        push(8'h01, 3'd1, rand128(), 1'b0);
        repeat (20) cyc();
        chki("t4_single_pop", rd_cnt - rd0, 1);
        chki("t4_no_load_blocked", int'(last_load_cyc > p), 0);
        block_mask = '0;
        cyc();
        rel = cyc_n;
        wait_ev(10, gl, gd);
        chki("t4_load_after_ready", last_load_cyc - rel, 1);
        chk("t4_load_chan", ld_val, 8'h02);
        la = last_load_cyc;
        wait_ev(10, gl, gd);
        chki("t4_second_gap", last_load_cyc - la, 5);
        chk("t4_second_chan", ld_val, 8'h01);
        repeat (2) cyc();

        // Timeout drop, then the next queued frame is popped
        block_mask = '1;
        p = cyc_n;
        d0 = int'(drop_cnt);
        push(8'h08, 3'd2, rand128(), 1'b1);
        push(8'h10, 3'd5, rand128(), 1'b0);
        wait_ev(TIMEOUT + 10, gl, gd);
        chk("t5_is_drop", gd, 1'b1);
        chki("t5_drop_time", last_drop_cyc - (p + 3), TIMEOUT);
        chki("t5_drop_cnt", int'(drop_cnt), d0 + 1);
        block_mask = '0;
        cyc();
        chki("t5_next_pop", last_rd_cyc, last_drop_cyc + 1);
        wait_ev(20, gl, gd);
        chk("t5_next_loads", gl, 1'b1);
        repeat (2) cyc();

        // en falls mid-frame: current frame completes, no further pop
        rd0 = rd_cnt;
        push(8'h40, 3'd4, rand128(), 1'b0);
        push(8'h40, 3'd0, rand128(), 1'b0);
        cyc();
        en = 1'b0;
        wait_ev(10, gl, gd);
        chk("t7_inflight_done", gl, 1'b1);
        repeat (8) cyc();
        chki("t7_no_pop_disabled", rd_cnt - rd0, 1);
        en = 1'b1;
        wait_ev(20, gl, gd);
        chk("t7_resume", gl, 1'b1);
        repeat (2) cyc();

        // Asynchronous reset while waiting on a stalled serializer
        block_mask = 8'h04;
        push(8'h04, 3'd0, rand128(), 1'b0);
        repeat (6) cyc();
        @(posedge clk_out);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("t6_async");
        eq.delete();
        fq.delete();
        m_loads = 0;
        m_drops = 0;
        block_mask = '0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        p = cyc_n;
        push(8'h04, 3'd1, 128'hBEEF_0000_CAFE, 1'b0);
        wait_ev(20, gl, gd);
        chki("t6_resume_latency", last_load_cyc - p, 4);
        chk("t6_frame_cnt", frame_cnt, 16'd1);
        repeat (2) cyc();

        // Randomized traffic against the frame-level model
        hold_max = 6;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 7) == 0) en = ~en;
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 3) != 0)
                    push(8'h01 << $urandom_range(0, 7), 3'($urandom_range(0, 7)), rand128(), 1'b0);
                else
                    push(8'($urandom()), 3'($urandom_range(0, 7)), rand128(), 1'b0);
            end
            cyc();
        end
        en = 1'b1;
        guard = 0;
        while (eq.size() > 0 && guard < 3000) begin
            cyc();
            guard++;
        end
        chki("rand_drained", eq.size(), 0);
        repeat (3) cyc();
        chki("rand_frame_cnt", int'(frame_cnt), m_loads);
        chki("rand_drop_cnt", int'(drop_cnt), m_drops);
        chk("rand_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
